// File: rtl/unit_wb_fifo_if.sv
// Bundles the result handshake and the writeback handshake of unit_wb_fifo.
// The slave modport is the FIFO side. The master modport is the side that
// drives results in and acknowledges writebacks.
interface unit_wb_fifo_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
);
  // Result push side
  logic                      result_valid;
  logic [ID_WIDTH-1:0]       result_id;
  logic [DATA_WIDTH-1:0]     result_data;
  logic                      result_ready;

  // Writeback pop side
  logic                      done;
  logic [ID_WIDTH-1:0]       id;
  logic [DATA_WIDTH-1:0]     rd;
  logic                      ack;

  // Occupancy
  logic [$clog2(DEPTH):0]    count;

  modport slave (
    input  result_valid, result_id, result_data, ack,
    output result_ready, done, id, rd, count
  );

  modport master (
    output result_valid, result_id, result_data, ack,
    input  result_ready, done, id, rd, count
  );
endinterface

// File: rtl/unit_wb_fifo.sv
// unit_wb_fifo: in-order result buffer between execution and writeback.
// Results are pushed on result_valid & result_ready. The head result is
// presented on done/id/rd and is popped on ack & done.
// Optional feature macro: UNIT_WB_FIFO_BYPASS_EN. When it is defined, an
// empty FIFO forwards an incoming result combinationally to the writeback
// side. A result that is acked in that same cycle is never stored.
module unit_wb_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  unit_wb_fifo_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_WIDTH + DATA_WIDTH;

  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  // Storage and bookkeeping.
  logic [EW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  // Derived controls.
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_bypass;
  logic           w_wr_en;
  logic           w_rd_en;
  logic [EW-1:0]  w_head;
  logic [CW-1:0]  w_count_next;

  assign w_empty = (r_count == CNT_ZERO);
  assign w_head  = r_mem[r_rd_ptr];

  // Ready depends only on registered occupancy, so ack never reaches it.
  assign bus.result_ready = (r_count != CNT_FULL);
  assign bus.count        = r_count;

  assign w_push = bus.result_valid & bus.result_ready;
  assign w_pop  = bus.ack & bus.done;

`ifdef UNIT_WB_FIFO_BYPASS_EN
  // A forwarded result that is acked at once never touches the storage.
  assign w_bypass = w_empty & w_push & bus.ack;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed pop must not advance the read pointer. Nothing was stored.
  assign w_wr_en = w_push & ~w_bypass;
  assign w_rd_en = w_pop  & ~w_bypass;

  // Present the head entry, or the incoming result when forwarding is enabled.
  always_comb begin
    bus.done = ~w_empty;
    bus.id   = w_head[EW-1:DATA_WIDTH];
    bus.rd   = w_head[DATA_WIDTH-1:0];
`ifdef UNIT_WB_FIFO_BYPASS_EN
    if (w_empty && bus.result_valid) begin
      bus.done = 1'b1;
      bus.id   = bus.result_id;
      bus.rd   = bus.result_data;
    end
`endif
  end

  // Occupancy update. A simultaneous write and read leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Pointer and count state. Reset is asynchronous, so mid-run entries are dropped at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  // Entry storage has no reset. Stale contents are hidden while count is 0.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {bus.result_id, bus.result_data};
    end
  end

endmodule

// File: tb/tb_unit_wb_fifo.sv
// Testbench for unit_wb_fifo, using directed vectors and a scoreboard.
// The stimulus queues each expected {id, rd} when it issues an accepted push.
// A monitor pops the queue and compares at every writeback handshake.
module tb_unit_wb_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int IW    = 3;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [IW+DW-1:0] exp_q [$];

  unit_wb_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  unit_wb_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a result and record the expected output. The caller must know it will be accepted.
  task automatic drive_push(input logic [IW-1:0] id, input logic [DW-1:0] data);
    bus.result_valid = 1'b1;
    bus.result_id    = id;
    bus.result_data  = data;
    exp_q.push_back({id, data});
  endtask

  // Scoreboard monitor: every writeback handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done && bus.ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual id=%0d rd=%0h required=no pop", bus.id, bus.rd);
      end else begin
        logic [IW+DW-1:0] e;
        e = exp_q.pop_front();
        $display("POP id=%0d rd=%08h expected id=%0d rd=%08h", bus.id, bus.rd, e[IW+DW-1:DW], e[DW-1:0]);
        check("pop_id", 64'(bus.id), 64'(e[IW+DW-1:DW]));
        check("pop_rd", 64'(bus.rd), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    bus.result_valid = 1'b0;
    bus.result_id    = '0;
    bus.result_data  = '0;
    bus.ack          = 1'b0;
    rst_n            = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_done",  64'(bus.done), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_ready", 64'(bus.result_ready), 64'd1);
    step();
    step();
    rst_n = 1'b1;

    // Single result into an empty FIFO, held until it is acked.
    drive_push(3'd2, 32'hDEADBEEF);
`ifndef UNIT_WB_FIFO_BYPASS_EN
    #1 check("lat_done_before_edge", 64'(bus.done), 64'd0);
`endif
    step();
    bus.result_valid = 1'b0;
    check("single_done",  64'(bus.done), 64'd1);
    check("single_id",    64'(bus.id), 64'd2);
    check("single_rd",    64'(bus.rd), 64'hDEADBEEF);
    check("single_count", 64'(bus.count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stable_id", 64'(bus.id), 64'd2);
      check("stable_rd", 64'(bus.rd), 64'hDEADBEEF);
    end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("single_drained", 64'(bus.count), 64'd0);

    // Fill to full, then check that a further valid is not consumed.
    for (int i = 0; i < 4; i++) begin
      drive_push(IW'(i), 32'h1000_0000 + 32'(i));
      step();
    end
    bus.result_valid = 1'b0;
    check("full_count", 64'(bus.count), 64'd4);
    check("full_ready", 64'(bus.result_ready), 64'd0);
    bus.result_valid = 1'b1;
    bus.result_id    = 3'd4;
    bus.result_data  = 32'h1000_0004;
    step();
    step();
    check("full_hold_count", 64'(bus.count), 64'd4);
    check("full_hold_head",  64'(bus.id), 64'd0);
    bus.result_valid = 1'b0;
    bus.ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.ack = 1'b0;
    check("full_drained", 64'(bus.count), 64'd0);

    // Hold two entries, then push and pop together long enough to wrap the pointers.
    drive_push(3'd6, 32'hC000_0006);
    step();
    drive_push(3'd7, 32'hC000_0007);
    step();
    check("pp_count_start", 64'(bus.count), 64'd2);
    bus.ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_push(IW'(i), 32'hC100_0000 + 32'(i));
      step();
      check("pp_count", 64'(bus.count), 64'd2);
    end
    bus.result_valid = 1'b0;
    step();
    step();
    bus.ack = 1'b0;
    check("pp_drained", 64'(bus.count), 64'd0);

    // An ack while empty has no effect.
    bus.ack = 1'b1;
    step();
    step();
    check("ack_empty_count", 64'(bus.count), 64'd0);
    check("ack_empty_done",  64'(bus.done), 64'd0);
    bus.ack = 1'b0;

    // Asynchronous reset between edges while three entries are buffered.
    for (int i = 1; i <= 3; i++) begin
      drive_push(IW'(i), 32'hE000_0000 + 32'(i));
      step();
    end
    bus.result_valid = 1'b0;
    check("pre_rst_count", 64'(bus.count), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_done",  64'(bus.done), 64'd0);
    check("async_rst_count", 64'(bus.count), 64'd0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    drive_push(3'd5, 32'h5555_AAAA);
    step();
    bus.result_valid = 1'b0;
    check("post_rst_count", 64'(bus.count), 64'd1);
    check("post_rst_id",    64'(bus.id), 64'd5);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    step();
    check("post_rst_drained", 64'(bus.done), 64'd0);

`ifdef UNIT_WB_FIFO_BYPASS_EN
    // Forwarding from empty. An acked result is not stored; an unacked one is.
    drive_push(3'd1, 32'hB0B0_0001);
    bus.ack = 1'b1;
    #1;
    check("byp_done", 64'(bus.done), 64'd1);
    check("byp_id",   64'(bus.id), 64'd1);
    step();
    bus.result_valid = 1'b0;
    bus.ack = 1'b0;
    check("byp_acked_count", 64'(bus.count), 64'd0);
    drive_push(3'd1, 32'hB0B0_0002);
    step();
    bus.result_valid = 1'b0;
    check("byp_unacked_count", 64'(bus.count), 64'd1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
`endif

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
